// File: rtl/timer_sched_ctrl.sv
// Programmable timer: prescaled up-counter with compare match, one-shot/periodic
// modes and a sticky interrupt with acknowledge and overrun tracking.
module timer_sched_ctrl #(
  parameter int N = 32,
  parameter int P = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Pwr_off,
  input  logic         Wr_en,
  input  logic [1:0]   Wr_addr,
  input  logic [N-1:0] Wr_data,
  input  logic         Irq_ack,
  output logic [N-1:0] Vout,
  output logic         Irq,
  output logic         Overrun,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cmp_q;
  logic [P-1:0] pcnt_q, presc_q;
  logic         periodic_q, irq_q, ovr_q;

  logic wr_ctrl, start, stop, clr, tick_en, tick, match;

  always_comb begin
    wr_ctrl = Wr_en && (Wr_addr == 2'd0);
    start   = wr_ctrl && Wr_data[0];
    stop    = wr_ctrl && Wr_data[2];
    // Any CTRL START/STOP pulse preempts counting on that edge.
    tick_en = (state_q == RUN) && !start && !stop;
    tick    = tick_en && (pcnt_q == presc_q);
    match   = tick && (cnt_q == cmp_q);
    // START (alone or with STOP) clears the counters; plain STOP just freezes.
    clr     = start;
  end

  always_comb begin
    state_d = state_q;
    if (stop)
      state_d = IDLE;
    else if (start)
      state_d = RUN;
    else if (match && !periodic_q)
      state_d = DONE_ST;
  end

  always_ff @(posedge Clk) begin
    if (Rst || Pwr_off) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      cmp_q      <= '1;
      presc_q    <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (Wr_en) begin
        case (Wr_addr)
          2'd0:    periodic_q <= Wr_data[1];
          2'd1:    cmp_q      <= Wr_data;
          2'd2:    presc_q    <= Wr_data[P-1:0];
          default: ;
        endcase
      end

      if (clr) begin
        cnt_q  <= '0;
        pcnt_q <= '0;
      end else if (tick_en) begin
        pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
        if (tick)
          cnt_q <= match ? '0 : cnt_q + 1'b1;
      end

      // A match wins over a same-cycle ack for Irq; ack always clears Overrun.
      if (match)
        irq_q <= 1'b1;
      else if (Irq_ack)
        irq_q <= 1'b0;

      if (Irq_ack)
        ovr_q <= 1'b0;
      else if (match && irq_q)
        ovr_q <= 1'b1;
    end
  end

  assign Vout    = cnt_q;
  assign Irq     = irq_q;
  assign Overrun = ovr_q;
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE_ST);

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Directed bench for timer_sched_ctrl: reset, periodic, prescaled one-shot,
// ack collision, control priority and power-off.
module tb_timer_sched_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Pwr_off, Wr_en, Irq_ack;
  logic [1:0]  Wr_addr;
  logic [31:0] Wr_data;
  logic [31:0] Vout;
  logic        Irq, Overrun, Busy, Done;

  int checks = 0;
  int errors = 0;

  timer_sched_ctrl #(.N(32), .P(8)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
    .Wr_data(Wr_data), .Irq_ack(Irq_ack), .Vout(Vout), .Irq(Irq),
    .Overrun(Overrun), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Wr_en = 1'b1; Wr_addr = a; Wr_data = d;
    cyc();
    Wr_en = 1'b0; Wr_addr = 2'd0; Wr_data = '0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] v, input logic irq,
                         input logic ovr, input logic busy, input logic done);
    chk({tag, "_vout"}, Vout, v);
    chk({tag, "_irq"},  {31'b0, Irq}, {31'b0, irq});
    chk({tag, "_ovr"},  {31'b0, Overrun}, {31'b0, ovr});
    chk({tag, "_busy"}, {31'b0, Busy}, {31'b0, busy});
    chk({tag, "_done"}, {31'b0, Done}, {31'b0, done});
  endtask

  initial begin
    Rst = 1'b1; Pwr_off = 1'b0; Irq_ack = 1'b0;
    Wr_en = 1'b1; Wr_addr = 2'd0; Wr_data = 32'd1;
    // Reset with a START write pending: write must be ignored
    cyc(2);
    chk_all("rst", 0, 0, 0, 0, 0);
    chk("rst_cmp", dut.cmp_q, 32'hFFFF_FFFF);
    Rst = 1'b0; Wr_en = 1'b0;

    wr(2'd0, 32'h1);
    chk_all("start", 0, 0, 0, 1, 0);
    cyc(); chk("cnt1", Vout, 1);
    cyc(); chk("cnt2", Vout, 2);
    cyc(); chk("cnt3", Vout, 3);

    // Periodic, no prescale, CMP=3
    wr(2'd2, 32'h0);  chk("run_presc_wr", Vout, 4);
    wr(2'd1, 32'h3);  chk("run_cmp_wr", Vout, 5);
    wr(2'd0, 32'h3);  chk_all("per_start", 0, 0, 0, 1, 0);
    cyc(); chk("per1", Vout, 1);
    cyc(); chk("per2", Vout, 2);
    cyc(); chk("per3", Vout, 3);
    cyc(); chk_all("per_match1", 0, 1, 0, 1, 0);
    cyc(3); chk("per_pre2", Vout, 3); chk("per_pre2_ovr", {31'b0, Overrun}, 0);
    cyc(); chk_all("per_match2", 0, 1, 1, 1, 0);
    Irq_ack = 1'b1; cyc(); Irq_ack = 1'b0;
    chk_all("per_ack", 1, 0, 0, 1, 0);

    // Prescaled one-shot: PRESC=2, CMP=1
    wr(2'd2, 32'h2);  chk("os_presc_wr", Vout, 2);
    wr(2'd1, 32'h1);  chk("os_cmp_wr", Vout, 2);
    wr(2'd0, 32'h1);  chk_all("os_start", 0, 0, 0, 1, 0);
    cyc(2); chk("os_c2", Vout, 0);
    cyc();  chk("os_c3", Vout, 1);
    cyc(2); chk("os_c5", Vout, 1); chk("os_c5_irq", {31'b0, Irq}, 0);
    cyc();  chk_all("os_c6", 0, 1, 0, 0, 1);
    cyc(3); chk_all("os_hold", 0, 1, 0, 0, 1);
    Irq_ack = 1'b1; cyc(); Irq_ack = 1'b0;
    chk_all("os_ack", 0, 0, 0, 0, 1);

    // START from DONE, then START+STOP in RUN
    wr(2'd0, 32'h1);  chk_all("done_restart", 0, 0, 0, 1, 0);
    cyc(3); chk("dr_c3", Vout, 1);
    wr(2'd0, 32'h5);  chk_all("start_stop", 0, 0, 0, 0, 0);
    cyc(2); chk_all("idle_frozen", 0, 0, 0, 0, 0);

    // Ack collision: CMP=0, PRESC=0 periodic -> match every cycle
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h3);  chk_all("col_start", 0, 0, 0, 1, 0);
    cyc(); chk_all("col_m1", 0, 1, 0, 1, 0);
    Irq_ack = 1'b1; cyc(); Irq_ack = 1'b0;
    chk_all("col_ack", 0, 1, 0, 1, 0);
    cyc(); chk_all("col_ovr", 0, 1, 1, 1, 0);

    // Power-off mid-run with Vout=5, Irq=1
    wr(2'd1, 32'h9);  chk("po_cmp_wr", Vout, 0);
    cyc(5); chk_all("po_pre", 5, 1, 1, 1, 0);
    Pwr_off = 1'b1; cyc(); Pwr_off = 1'b0;
    chk_all("po", 0, 0, 0, 0, 0);
    chk("po_cmp", dut.cmp_q, 32'hFFFF_FFFF);
    cyc(2); chk_all("po_frozen", 0, 0, 0, 0, 0);
    wr(2'd0, 32'h3);  chk_all("po_restart", 0, 0, 0, 1, 0);
    cyc(); chk("po_cnt1", Vout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
